// File: rtl/common_pkg.sv
// rtl/common_pkg.sv - shared router types and defaults
// Purpose: tile transaction type, output link state encoding and the shared
//          link credit default used by router output stages.
// Ports:   none (package).
package common_pkg;

  typedef struct packed {
    logic [7:0]  id;
    logic [3:0]  dst;
    logic [19:0] payload;
  } t_tile_trans;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    SEND  = 2'b01,
    STALL = 2'b10
  } t_link_state;

  // Shared with the router FIFO depth parameter so both ends of a link agree.
  localparam int ROUTER_LINK_CREDITS = 4;

endpackage

// File: rtl/router_out_skid_buf.sv
// rtl/router_out_skid_buf.sv - 2-entry in-order skid buffer for the output link
// Purpose: circular 2-entry FIFO with 1-bit read/write pointers and a 2-bit count.
// Ports:
//   clk, rst_n       clock, asynchronous active-low reset
//   push, push_trans write one entry (caller guarantees count<2)
//   pop              remove head entry (caller guarantees count!=0)
//   count            registered occupancy
//   count_nxt        occupancy after the coming edge
//   head             head entry; holds the last popped value while empty
module router_out_skid_buf
  import common_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        push,
  input  t_tile_trans push_trans,
  input  logic        pop,
  output logic [1:0]  count,
  output logic [1:0]  count_nxt,
  output t_tile_trans head
);

  t_tile_trans [1:0] mem_q, mem_d;
  t_tile_trans       last_q, last_d;
  logic              wr_ptr_q, wr_ptr_d;
  logic              rd_ptr_q, rd_ptr_d;
  logic [1:0]        count_q, count_d;

  always_comb begin
    mem_d    = mem_q;
    last_d   = last_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;

    // Storage is only written on push so an X on in_trans never reaches state.
    if (push) begin
      mem_d[wr_ptr_q] = push_trans;
      wr_ptr_d        = ~wr_ptr_q;
    end

    // Remember what left the buffer so the link view is stable once drained.
    if (pop) begin
      last_d   = mem_q[rd_ptr_q];
      rd_ptr_d = ~rd_ptr_q;
    end

    case ({push, pop})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q    <= '0;
      last_q   <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      mem_q    <= mem_d;
      last_q   <= last_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign count     = count_q;
  assign count_nxt = count_d;
  assign head      = (count_q != 2'd0) ? mem_q[rd_ptr_q] : last_q;

endmodule

// File: rtl/router_out_credit.sv
// rtl/router_out_credit.sv - router output link stage with credit flow control
// Purpose: buffers the fifo_arb winner in a 2-entry skid buffer and launches it
//          on the inter-router link when the neighbour has credit; reports link
//          state, stall cycles and credit overflow.
// Ports:
//   clk, rst_n           clock, asynchronous active-low reset
//   in_valid/in_trans    winner from fifo_arb; in_ready = buffer can accept
//   out_valid/out_trans  transaction launched this cycle (no link ready)
//   credit_ret           one-cycle pulse, neighbour freed one entry
//   credit_cnt           current credits
//   link_state           00 IDLE, 01 SEND, 10 STALL
//   stall_cnt            saturating count of STALL cycles
//   credit_err           sticky credit overflow flag
module router_out_credit
  import common_pkg::*;
#(
  parameter int NUM_CREDITS = ROUTER_LINK_CREDITS,
  parameter int CNT_W       = $clog2(NUM_CREDITS + 1),
  parameter int STALL_W     = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  input  t_tile_trans        in_trans,
  output logic               in_ready,
  output logic               out_valid,
  output t_tile_trans        out_trans,
  input  logic               credit_ret,
  output logic [CNT_W-1:0]   credit_cnt,
  output logic [1:0]         link_state,
  output logic [STALL_W-1:0] stall_cnt,
  output logic               credit_err
);

  localparam logic [CNT_W-1:0] CRED_MAX = CNT_W'(NUM_CREDITS);

  logic [1:0]         count, count_nxt;
  logic               push, send;
  logic [CNT_W-1:0]   credit_cnt_q, credit_cnt_d;
  logic               credit_err_q, credit_err_d;
  t_link_state        link_state_q, link_state_d;
  logic [STALL_W-1:0] stall_cnt_q, stall_cnt_d;

  // Ready comes from registered occupancy only: no path from credit_ret or the
  // send decision, so a full buffer refuses even when it is draining this cycle.
  assign in_ready = (count != 2'd2);
  assign push     = in_valid && in_ready;
  assign send     = (count != 2'd0) && (credit_cnt_q != '0);

  router_out_skid_buf u_skid_buf (
    .clk        (clk),
    .rst_n      (rst_n),
    .push       (push),
    .push_trans (in_trans),
    .pop        (send),
    .count      (count),
    .count_nxt  (count_nxt),
    .head       (out_trans)
  );

  always_comb begin
    credit_cnt_d = credit_cnt_q;
    credit_err_d = credit_err_q;
    if (send && !credit_ret) begin
      credit_cnt_d = credit_cnt_q - CNT_W'(1);
    end else if (credit_ret && !send) begin
      if (credit_cnt_q == CRED_MAX) begin
        credit_err_d = 1'b1;
      end else begin
        credit_cnt_d = credit_cnt_q + CNT_W'(1);
      end
    end
  end

  // State reflects the values that will be registered at this edge.
  always_comb begin
    link_state_d = link_state_q;
    if (count_nxt == 2'd0) begin
      link_state_d = IDLE;
    end else if (credit_cnt_d != '0) begin
      link_state_d = SEND;
    end else begin
      link_state_d = STALL;
    end
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if ((count != 2'd0) && (credit_cnt_q == '0) && (stall_cnt_q != '1)) begin
      stall_cnt_d = stall_cnt_q + STALL_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      credit_cnt_q <= CRED_MAX;
      credit_err_q <= 1'b0;
      link_state_q <= IDLE;
      stall_cnt_q  <= '0;
    end else begin
      credit_cnt_q <= credit_cnt_d;
      credit_err_q <= credit_err_d;
      link_state_q <= link_state_d;
      stall_cnt_q  <= stall_cnt_d;
    end
  end

  assign out_valid  = send;
  assign credit_cnt = credit_cnt_q;
  assign credit_err = credit_err_q;
  assign link_state = link_state_q;
  assign stall_cnt  = stall_cnt_q;

endmodule

// File: tb/tb_router_out_credit.sv
// tb/tb_router_out_credit.sv - directed self-checking bench for router_out_credit
module tb_router_out_credit;
  import common_pkg::*;

  logic         clk;
  logic         rst_n;
  logic         in_valid;
  t_tile_trans  in_trans;
  logic         in_ready;
  logic         out_valid;
  t_tile_trans  out_trans;
  logic         credit_ret;
  logic [2:0]   credit_cnt;
  logic [1:0]   link_state;
  logic [15:0]  stall_cnt;
  logic         credit_err;

  int checks = 0;
  int errors = 0;

  router_out_credit dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_trans   (in_trans),
    .in_ready   (in_ready),
    .out_valid  (out_valid),
    .out_trans  (out_trans),
    .credit_ret (credit_ret),
    .credit_cnt (credit_cnt),
    .link_state (link_state),
    .stall_cnt  (stall_cnt),
    .credit_err (credit_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic t_tile_trans mk(input logic [7:0] id);
    t_tile_trans t;
    t.id      = id;
    t.dst     = id[3:0] ^ 4'h5;
    t.payload = {id, ~id, 4'hA};
    return t;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    in_valid   = 1'b0;
    credit_ret = 1'b0;
    rst_n      = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    step();
  endtask

  task automatic test_reset();
    in_valid   = 1'b0;
    in_trans   = '0;
    credit_ret = 1'b0;
    rst_n      = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    checks++; if (credit_cnt !== 3'd4) begin errors++; $display("FAIL reset_credit: got %0d expected 4", credit_cnt); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
    checks++; if (link_state !== 2'b00) begin errors++; $display("FAIL reset_link_state: got %b expected 00", link_state); end
    checks++; if (stall_cnt !== 16'd0) begin errors++; $display("FAIL reset_stall_cnt: got %0d expected 0", stall_cnt); end
    checks++; if (credit_err !== 1'b0) begin errors++; $display("FAIL reset_credit_err: got %b expected 0", credit_err); end
    checks++; if (out_trans !== t_tile_trans'('0)) begin errors++; $display("FAIL reset_out_trans: got %h expected 0", out_trans); end
    rst_n = 1'b1;
    step();
    in_valid = 1'b1; in_trans = mk(8'd9);
    step();
    in_trans = mk(8'd10);
    step();
    in_valid = 1'b0;
    checks++; if (out_valid !== 1'b1 || credit_cnt !== 3'd3) begin errors++; $display("FAIL pre_async_state: got valid=%b credit=%0d expected valid=1 credit=3", out_valid, credit_cnt); end
    #3 rst_n = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL async_out_valid: got %b expected 0", out_valid); end
    checks++; if (credit_cnt !== 3'd4) begin errors++; $display("FAIL async_credit: got %0d expected 4", credit_cnt); end
    checks++; if (link_state !== 2'b00) begin errors++; $display("FAIL async_link_state: got %b expected 00", link_state); end
    checks++; if (out_trans !== t_tile_trans'('0)) begin errors++; $display("FAIL async_out_trans: got %h expected 0", out_trans); end
    @(posedge clk);
    #1 rst_n = 1'b1;
    step();
  endtask

  task automatic test_credit_exhaustion();
    for (int i = 0; i < 6; i++) begin
      in_valid = 1'b1;
      in_trans = mk(8'(i));
      step();
      checks++; if (out_valid !== 1'(i < 4)) begin errors++; $display("FAIL exh_out_valid[%0d]: got %b expected %b", i, out_valid, (i < 4)); end
      if (i < 4) begin
        checks++; if (out_trans !== mk(8'(i))) begin errors++; $display("FAIL exh_order[%0d]: got %h expected %h", i, out_trans, mk(8'(i))); end
      end
      checks++; if (credit_cnt !== 3'((i < 4) ? (4 - i) : 0)) begin errors++; $display("FAIL exh_credit[%0d]: got %0d expected %0d", i, credit_cnt, (i < 4) ? (4 - i) : 0); end
      checks++; if (in_ready !== 1'(i != 5)) begin errors++; $display("FAIL exh_in_ready[%0d]: got %b expected %b", i, in_ready, (i != 5)); end
    end
    in_valid = 1'b0;
    checks++; if (stall_cnt !== 16'd1) begin errors++; $display("FAIL exh_stall_first: got %0d expected 1", stall_cnt); end
    for (int j = 0; j < 3; j++) begin
      step();
      checks++; if (stall_cnt !== 16'(2 + j)) begin errors++; $display("FAIL exh_stall_cnt[%0d]: got %0d expected %0d", j, stall_cnt, 2 + j); end
      checks++; if (link_state !== 2'b10) begin errors++; $display("FAIL exh_link_state[%0d]: got %b expected 10", j, link_state); end
      checks++; if (out_valid !== 1'b0 || out_trans !== mk(8'd4)) begin errors++; $display("FAIL exh_hold[%0d]: got valid=%b trans=%h expected valid=0 trans=%h", j, out_valid, out_trans, mk(8'd4)); end
    end
  endtask

  task automatic test_credit_return();
    credit_ret = 1'b1;
    step();
    credit_ret = 1'b0;
    checks++; if (out_valid !== 1'b1 || out_trans !== mk(8'd4)) begin errors++; $display("FAIL ret_send4: got valid=%b trans=%h expected valid=1 trans=%h", out_valid, out_trans, mk(8'd4)); end
    checks++; if (credit_cnt !== 3'd1) begin errors++; $display("FAIL ret_credit1: got %0d expected 1", credit_cnt); end
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL ret_in_ready_full: got %b expected 0", in_ready); end
    checks++; if (link_state !== 2'b01) begin errors++; $display("FAIL ret_link_send: got %b expected 01", link_state); end
    checks++; if (stall_cnt !== 16'd5) begin errors++; $display("FAIL ret_stall5: got %0d expected 5", stall_cnt); end
    step();
    checks++; if (credit_cnt !== 3'd0) begin errors++; $display("FAIL ret_credit0: got %0d expected 0", credit_cnt); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL ret_in_ready: got %b expected 1", in_ready); end
    checks++; if (out_valid !== 1'b0 || link_state !== 2'b10) begin errors++; $display("FAIL ret_restall: got valid=%b state=%b expected valid=0 state=10", out_valid, link_state); end
    checks++; if (stall_cnt !== 16'd5) begin errors++; $display("FAIL ret_stall_hold: got %0d expected 5", stall_cnt); end
    credit_ret = 1'b1;
    step();
    credit_ret = 1'b0;
    checks++; if (out_valid !== 1'b1 || out_trans !== mk(8'd5)) begin errors++; $display("FAIL ret_send5: got valid=%b trans=%h expected valid=1 trans=%h", out_valid, out_trans, mk(8'd5)); end
    checks++; if (stall_cnt !== 16'd6) begin errors++; $display("FAIL ret_stall6: got %0d expected 6", stall_cnt); end
    step();
    checks++; if (link_state !== 2'b00) begin errors++; $display("FAIL ret_idle: got %b expected 00", link_state); end
    checks++; if (out_valid !== 1'b0 || out_trans !== mk(8'd5)) begin errors++; $display("FAIL ret_last_head: got valid=%b trans=%h expected valid=0 trans=%h", out_valid, out_trans, mk(8'd5)); end
    checks++; if (credit_cnt !== 3'd0 || stall_cnt !== 16'd6) begin errors++; $display("FAIL ret_final: got credit=%0d stall=%0d expected credit=0 stall=6", credit_cnt, stall_cnt); end
  endtask

  task automatic test_simultaneous();
    apply_reset();
    in_valid = 1'b1; in_trans = mk(8'd20);
    step();
    in_trans = mk(8'd21);
    step();
    checks++; if (out_valid !== 1'b1 || out_trans !== mk(8'd21) || credit_cnt !== 3'd3) begin errors++; $display("FAIL sim_pushpop1: got valid=%b trans=%h credit=%0d expected valid=1 trans=%h credit=3", out_valid, out_trans, credit_cnt, mk(8'd21)); end
    in_trans = mk(8'd22);
    step();
    in_valid = 1'b0;
    checks++; if (out_valid !== 1'b1 || out_trans !== mk(8'd22) || in_ready !== 1'b1) begin errors++; $display("FAIL sim_pushpop2: got valid=%b trans=%h ready=%b expected valid=1 trans=%h ready=1", out_valid, out_trans, in_ready, mk(8'd22)); end
    checks++; if (credit_cnt !== 3'd2) begin errors++; $display("FAIL sim_credit_before: got %0d expected 2", credit_cnt); end
    credit_ret = 1'b1;
    step();
    credit_ret = 1'b0;
    checks++; if (credit_cnt !== 3'd2) begin errors++; $display("FAIL sim_send_and_ret: got %0d expected 2", credit_cnt); end
    checks++; if (out_valid !== 1'b0 || link_state !== 2'b00) begin errors++; $display("FAIL sim_drained: got valid=%b state=%b expected valid=0 state=00", out_valid, link_state); end
  endtask

  task automatic test_overflow();
    credit_ret = 1'b1;
    step();
    step();
    credit_ret = 1'b0;
    checks++; if (credit_cnt !== 3'd4 || credit_err !== 1'b0) begin errors++; $display("FAIL ovf_refill: got credit=%0d err=%b expected credit=4 err=0", credit_cnt, credit_err); end
    credit_ret = 1'b1;
    step();
    credit_ret = 1'b0;
    checks++; if (credit_cnt !== 3'd4) begin errors++; $display("FAIL ovf_saturate: got %0d expected 4", credit_cnt); end
    checks++; if (credit_err !== 1'b1) begin errors++; $display("FAIL ovf_err_set: got %b expected 1", credit_err); end
    repeat (3) step();
    checks++; if (credit_err !== 1'b1) begin errors++; $display("FAIL ovf_err_sticky: got %b expected 1", credit_err); end
  endtask

  task automatic test_mid_reset();
    for (int i = 0; i < 6; i++) begin
      in_valid = 1'b1;
      in_trans = mk(8'(10 + i));
      step();
    end
    in_valid = 1'b0;
    checks++; if (link_state !== 2'b10 || in_ready !== 1'b0 || out_valid !== 1'b0) begin errors++; $display("FAIL mid_pre_stall: got state=%b ready=%b valid=%b expected state=10 ready=0 valid=0", link_state, in_ready, out_valid); end
    #3 rst_n = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0 || credit_cnt !== 3'd4) begin errors++; $display("FAIL mid_async: got valid=%b credit=%0d expected valid=0 credit=4", out_valid, credit_cnt); end
    checks++; if (link_state !== 2'b00 || stall_cnt !== 16'd0 || in_ready !== 1'b1) begin errors++; $display("FAIL mid_async_state: got state=%b stall=%0d ready=%b expected state=00 stall=0 ready=1", link_state, stall_cnt, in_ready); end
    checks++; if (credit_err !== 1'b0) begin errors++; $display("FAIL mid_err_cleared: got %b expected 0", credit_err); end
    @(posedge clk);
    #1 rst_n = 1'b1;
    for (int k = 0; k < 8; k++) begin
      step();
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL mid_flush[%0d]: got valid=%b trans=%h expected no emission", k, out_valid, out_trans); end
    end
    checks++; if (credit_cnt !== 3'd4 || link_state !== 2'b00) begin errors++; $display("FAIL mid_after: got credit=%0d state=%b expected credit=4 state=00", credit_cnt, link_state); end
  endtask

  initial begin
    test_reset();
    test_credit_exhaustion();
    test_credit_return();
    test_simultaneous();
    test_overflow();
    test_mid_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
